// File: rtl/cpu_clk_ctrl.sv
// Clock-enable sequencer for the multi-cycle CPU: turns a bouncy step button or a run
// switch into single-cycle cpu_en pulses, latches a halt, and counts issued CPU cycles.
module cpu_clk_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int RUN_DIV         = 4,
    parameter int CNT_W           = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             step_btn,
    input  logic             run_sw,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       state
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int VW = $clog2(RUN_DIV + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [VW-1:0] DIV_LAST  = VW'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        ST_STEP = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t        st;
    logic          btn_meta, btn_s;
    logic          run_meta, run_s;
    logic [DW-1:0] dcnt;
    logic          btn_db, btn_db_d;
    logic [VW-1:0] div;
    logic          step_req;

    // NOTE: every flop below uses non-blocking assignment so all registers see the
    // pre-edge values of each other, which is what makes the two-flop synchronizers work.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            run_meta <= 1'b0;
            run_s    <= 1'b0;
        end else begin
            btn_meta <= step_btn;
            btn_s    <= btn_meta;
            run_meta <= run_sw;
            run_s    <= run_meta;
        end
    end

    // The debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            dcnt     <= '0;
            btn_db   <= 1'b0;
            btn_db_d <= 1'b0;
        end else begin
            btn_db_d <= btn_db;
            if (btn_s == btn_db) begin
                dcnt <= '0;
            end else if (dcnt == DCNT_LAST) begin
                btn_db <= btn_s;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

    assign step_req = btn_db & ~btn_db_d;

    // Halt is checked first in every live state, so a due pulse is dropped at that edge.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            st     <= ST_STEP;
            div    <= '0;
            cpu_en <= 1'b0;
        end else begin
            cpu_en <= 1'b0;
            case (st)
                ST_STEP: begin
                    if (halt_req) begin
                        st <= ST_HALT;
                    end else if (run_s) begin
                        st  <= ST_RUN;
                        div <= '0;
                    end else if (step_req) begin
                        cpu_en <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        st <= ST_HALT;
                    end else if (!run_s) begin
                        st  <= ST_STEP;
                        div <= '0;
                    end else if (div == DIV_LAST) begin
                        div    <= '0;
                        cpu_en <= 1'b1;
                    end else begin
                        div <= div + VW'(1);
                    end
                end
                ST_HALT: st <= ST_HALT;
                default: st <= ST_STEP;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else if (cpu_en && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    assign state = st;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: stimulus queues the edge and count of each expected
// cpu_en pulse; a negedge monitor pops and compares every pulse the DUT produces.
module tb_cpu_clk_ctrl;

    localparam int DEB = 4;
    localparam int DIV = 3;
    localparam int CW  = 4;

    logic          sys_clk = 1'b0;
    logic          reset;
    logic          step_btn;
    logic          run_sw;
    logic          halt_req;
    logic          cpu_en;
    logic [CW-1:0] cycle_cnt;
    logic [1:0]    state;

    typedef struct {
        int            edge_no;
        logic [CW-1:0] cnt;
    } pulse_t;

    pulse_t sb[$];
    int     edge_n  = 0;
    int     n_cmp   = 0;
    int     n_fail  = 0;

    cpu_clk_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .RUN_DIV        (DIV),
        .CNT_W          (CW)
    ) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .step_btn (step_btn),
        .run_sw   (run_sw),
        .halt_req (halt_req),
        .cpu_en   (cpu_en),
        .cycle_cnt(cycle_cnt),
        .state    (state)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Monitor: every cpu_en pulse must match the head of the scoreboard.
    always @(negedge sys_clk) begin
        if (cpu_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 0, 1);
            end else begin
                pulse_t p;
                p = sb.pop_front();
                check("pulse_edge", edge_n, p.edge_no);
                check("pulse_cnt", int'(cycle_cnt), int'(p.cnt));
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic expect_pulse(input int e, input int c);
        pulse_t p;
        p.edge_no = e;
        p.cnt     = (c > 15) ? 4'hF : CW'(c);
        sb.push_back(p);
    endtask

    task automatic drained(input string name);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset;
        @(negedge sys_clk);
        reset = 1'b0;
        wait_neg(2);
        check("rst_state", int'(state), 0);
        check("rst_cnt", int'(cycle_cnt), 0);
        reset = 1'b1;
        wait_neg(2);
    endtask

    initial begin
        int e0;
        reset    = 1'b0;
        step_btn = 1'b0;
        run_sw   = 1'b0;
        halt_req = 1'b0;

        // Reset held with inputs toggling: outputs stay at reset values.
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            step_btn = i[0];
            run_sw   = i[1];
            halt_req = i[2];
            check("rst_hold_en", int'(cpu_en), 0);
            check("rst_hold_cnt", int'(cycle_cnt), 0);
            check("rst_hold_state", int'(state), 0);
        end
        step_btn = 1'b0;
        run_sw   = 1'b0;
        halt_req = 1'b0;
        @(negedge sys_clk);
        reset = 1'b1;
        wait_neg(10);
        check("idle_state", int'(state), 0);
        check("idle_cnt", int'(cycle_cnt), 0);

        // Clean press: pulse in the cycle after edge DEB+3.
        e0 = edge_n;
        step_btn = 1'b1;
        expect_pulse(e0 + DEB + 3, 0);
        wait_neg(20);
        drained("press1_drained");
        check("press1_cnt", int'(cycle_cnt), 1);
        step_btn = 1'b0;
        wait_neg(10);
        e0 = edge_n;
        step_btn = 1'b1;
        expect_pulse(e0 + DEB + 3, 1);
        wait_neg(20);
        step_btn = 1'b0;
        wait_neg(10);
        drained("press2_drained");
        check("press2_cnt", int'(cycle_cnt), 2);

        // Bounce: highs of 1, 2 and 3 cycles never reach the debounce threshold.
        do_reset();
        for (int w = 1; w <= 3; w++) begin
            step_btn = 1'b1;
            wait_neg(w);
            step_btn = 1'b0;
            wait_neg(3);
        end
        wait_neg(10);
        drained("bounce_drained");
        check("bounce_cnt", int'(cycle_cnt), 0);

        // RUN mode for 30 cycles: 9 pulses at e0+6, e0+9, ... e0+30.
        e0 = edge_n;
        run_sw = 1'b1;
        for (int k = 0; k < 9; k++) expect_pulse(e0 + 6 + DIV * k, k);
        wait_neg(2);
        check("run_entry_pre", int'(state), 0);
        wait_neg(1);
        check("run_entry", int'(state), 1);
        wait_neg(27);
        run_sw = 1'b0;
        wait_neg(2);
        check("run_exit_pre", int'(state), 1);
        wait_neg(1);
        check("run_exit", int'(state), 0);
        wait_neg(10);
        drained("run_drained");
        check("run_cnt", int'(cycle_cnt), 9);

        // Halt sampled at an edge where div==2: that pulse is suppressed.
        e0 = edge_n;
        run_sw = 1'b1;
        expect_pulse(e0 + 6, 9);
        expect_pulse(e0 + 9, 10);
        wait_neg(11);
        halt_req = 1'b1;
        wait_neg(1);
        check("halt_state", int'(state), 2);
        check("halt_en", int'(cpu_en), 0);
        halt_req = 1'b0;
        run_sw   = 1'b0;
        wait_neg(5);
        step_btn = 1'b1;
        wait_neg(15);
        step_btn = 1'b0;
        run_sw   = 1'b1;
        wait_neg(10);
        run_sw   = 1'b0;
        wait_neg(10);
        check("halt_absorb", int'(state), 2);
        check("halt_cnt", int'(cycle_cnt), 11);
        drained("halt_drained");
        do_reset();
        check("halt_reset_state", int'(state), 0);

        // Saturation: 19 pulses in 60 RUN cycles, count sticks at 4'hF.
        e0 = edge_n;
        run_sw = 1'b1;
        for (int k = 0; k < 19; k++) expect_pulse(e0 + 6 + DIV * k, k);
        wait_neg(60);
        run_sw = 1'b0;
        wait_neg(10);
        drained("sat_drained");
        check("sat_cnt", int'(cycle_cnt), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
